// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit state encoding, parity selection
// and the 3-sample majority vote used for bit recovery.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRT,
    DATA,
    PRTY,
    STOP1,
    STOP2,
    VALD
  } uart_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit recovery: three samples around the bit centre, majority registered
// so the FSM sees a stable bit value (bit_rdy) two edges after the centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic                          clk,
  input  logic                          rx_in,
  input  logic [$clog2(OVERSAMPLE)-1:0] edge_cnt,
  output logic                          rx_bit,
  output logic                          bit_rdy
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int H  = OVERSAMPLE / 2;
  localparam logic [EW-1:0] EDGE_S0  = EW'(H - 1);
  localparam logic [EW-1:0] EDGE_S1  = EW'(H);
  localparam logic [EW-1:0] EDGE_S2  = EW'(H + 1);
  localparam logic [EW-1:0] EDGE_USE = EW'(H + 2);

  logic samp_a_p0;
  logic samp_b_p0;

  // p0: early/centre samples; p1: majority with the late sample taken live
  always_ff @(posedge clk) begin
    if (edge_cnt == EDGE_S0) samp_a_p0 <= rx_in;
    if (edge_cnt == EDGE_S1) samp_b_p0 <= rx_in;
    if (edge_cnt == EDGE_S2) rx_bit    <= maj3(samp_a_p0, samp_b_p0, rx_in);
  end

  assign bit_rdy = (edge_cnt == EDGE_USE);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection with line-armed guard, data/parity/stop
// sequencing, deserialisation and one-cycle status pulses.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  uart_state_e           state;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  armed;
  logic                  par_en_q;
  logic                  stop2_q;
  par_typ_e              par_typ_q;
  logic [DATA_WIDTH-1:0] shift_p1;
  logic                  rx_bit;
  logic                  bit_rdy;
  logic                  last_cycle;
  logic                  par_exp;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk      (clk),
    .rx_in    (rx_in),
    .edge_cnt (edge_cnt),
    .rx_bit   (rx_bit),
    .bit_rdy  (bit_rdy)
  );

  assign last_cycle = (edge_cnt == EDGE_LAST);
  assign par_exp    = (par_typ_q == PAR_ODD) ? ~^shift_p1 : ^shift_p1;
  assign busy       = (state != IDLE);

  // p1: LSB-first deserialiser, newest bit enters at the MSB
  always_ff @(posedge clk) begin
    if (state == DATA && bit_rdy) shift_p1 <= {rx_bit, shift_p1[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      armed       <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= PAR_EVEN;
      stop2_q     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      edge_cnt    <= edge_cnt + EW'(1);
      unique case (state)
        IDLE: begin
          edge_cnt <= '0;
          // a line that has not been seen high since reset or an error cannot start a frame
          if (rx_in) begin
            armed <= 1'b1;
          end else if (armed) begin
            state     <= STRT;
            edge_cnt  <= EW'(1);
            par_en_q  <= par_en;
            par_typ_q <= par_typ_e'(par_typ);
            stop2_q   <= stop2;
          end
        end
        STRT: begin
          if (bit_rdy && rx_bit) begin
            strt_glitch <= 1'b1;
            armed       <= 1'b0;
            state       <= IDLE;
          end else if (last_cycle) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (last_cycle) begin
            if (bit_cnt == BIT_LAST) state <= par_en_q ? PRTY : STOP1;
            else bit_cnt <= bit_cnt + BW'(1);
          end
        end
        PRTY: begin
          if (bit_rdy && (rx_bit != par_exp)) begin
            par_err <= 1'b1;
            armed   <= 1'b0;
            state   <= IDLE;
          end else if (last_cycle) begin
            state <= STOP1;
          end
        end
        STOP1: begin
          // leaving at mid-stop keeps a back-to-back start edge catchable
          if (bit_rdy) begin
            if (!rx_bit) begin
              stp_err <= 1'b1;
              armed   <= 1'b0;
              state   <= IDLE;
            end else if (!stop2_q) begin
              data_out   <= shift_p1;
              data_valid <= 1'b1;
              state      <= VALD;
            end
          end else if (last_cycle && stop2_q) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (bit_rdy) begin
            if (!rx_bit) begin
              stp_err <= 1'b1;
              armed   <= 1'b0;
              state   <= IDLE;
            end else begin
              data_out   <= shift_p1;
              data_valid <= 1'b1;
              state      <= VALD;
            end
          end
        end
        VALD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
